// File: rtl/rsv_station.sv
// ---------------------------------------------------------------------------
// rsv_station
//
// Reservation-station bank for one functional-unit class of the Tomasulo
// core. Issue logic delivers an operation whose operands are either values
// (Q == 0) or producer tags. The bank allocates the lowest free entry,
// reports that entry's tag back to the rename table, snoops the common data
// bus for pending operands, and offers ready operations to the functional
// unit over a valid/ready handshake.
//
// Optional build macro:
//   RSV_STATION_AGE_ORDER_EN - dispatch picks the oldest ready entry instead
//                              of the lowest-index ready entry. Allocation is
//                              unchanged. Undefined: no age logic is built.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous clear of every entry
//   issue_valid/ready issue handshake; ready while any entry is free
//   issue_op/vj/vk    incoming operation and operand values
//   issue_qj/qk       producer tags for the operands (0 = value valid)
//   issue_tag         tag of the entry the next issue will occupy
//   cdb_valid/tag/data common data bus broadcast
//   disp_valid/ready  dispatch handshake towards the functional unit
//   disp_op/a/b/tag   offered operation, operands and entry tag
//   busy_cnt          registered count of occupied entries
// ---------------------------------------------------------------------------
module rsv_station #(
  parameter int NUM_ENTRY = 4,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int TAG_BASE  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [OP_W-1:0]                  issue_op,
  input  logic [DATA_W-1:0]                issue_vj,
  input  logic [DATA_W-1:0]                issue_vk,
  input  logic [TAG_W-1:0]                 issue_qj,
  input  logic [TAG_W-1:0]                 issue_qk,
  output logic [TAG_W-1:0]                 issue_tag,
  input  logic                             cdb_valid,
  input  logic [TAG_W-1:0]                 cdb_tag,
  input  logic [DATA_W-1:0]                cdb_data,
  output logic                             disp_valid,
  input  logic                             disp_ready,
  output logic [OP_W-1:0]                  disp_op,
  output logic [DATA_W-1:0]                disp_a,
  output logic [DATA_W-1:0]                disp_b,
  output logic [TAG_W-1:0]                 disp_tag,
  output logic [$clog2(NUM_ENTRY+1)-1:0]   busy_cnt
);

  localparam int IDX_W = $clog2(NUM_ENTRY);
  localparam int CNT_W = $clog2(NUM_ENTRY+1);

  // Entry state
  logic [NUM_ENTRY-1:0] busy_q, busy_d;
  logic [OP_W-1:0]      op_q [NUM_ENTRY];
  logic [OP_W-1:0]      op_d [NUM_ENTRY];
  logic [DATA_W-1:0]    vj_q [NUM_ENTRY];
  logic [DATA_W-1:0]    vj_d [NUM_ENTRY];
  logic [DATA_W-1:0]    vk_q [NUM_ENTRY];
  logic [DATA_W-1:0]    vk_d [NUM_ENTRY];
  logic [TAG_W-1:0]     qj_q [NUM_ENTRY];
  logic [TAG_W-1:0]     qj_d [NUM_ENTRY];
  logic [TAG_W-1:0]     qk_q [NUM_ENTRY];
  logic [TAG_W-1:0]     qk_d [NUM_ENTRY];
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_ENTRY-1:0] ready;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     disp_idx;
  logic                 issue_fire;
  logic                 disp_fire;
  logic                 cdb_hit;
  logic                 bypass_j;
  logic                 bypass_k;

  // Lowest-index free entry; scanning downwards leaves the lowest match.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRY-1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign issue_ready = ~&busy_q;
  assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

`ifdef RSV_STATION_AGE_ORDER_EN
  // age_q counts how many busy entries were issued after this one, so the
  // oldest ready entry carries the largest value. Busy entries never share
  // an age, and the value is bounded by NUM_ENTRY-1.
  logic [IDX_W-1:0] age_q [NUM_ENTRY];
  logic [IDX_W-1:0] age_d [NUM_ENTRY];
  logic [IDX_W-1:0] disp_age;
  logic             sel_found;

  always_comb begin
    disp_idx  = '0;
    disp_age  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (ready[i] && (!sel_found || (age_q[i] > disp_age))) begin
        sel_found = 1'b1;
        disp_idx  = IDX_W'(i);
        disp_age  = age_q[i];
      end
    end
  end

  // A new entry starts at zero; every surviving older entry gains one per
  // issue and loses one when a younger entry leaves through dispatch.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      age_d[i] = age_q[i];
      if (flush) begin
        age_d[i] = '0;
      end else if (issue_fire && (free_idx == IDX_W'(i))) begin
        age_d[i] = '0;
      end else if (busy_q[i] && !(disp_fire && (disp_idx == IDX_W'(i)))) begin
        if (issue_fire && !(disp_fire && (age_q[i] > disp_age))) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end else if (!issue_fire && disp_fire && (age_q[i] > disp_age)) begin
          age_d[i] = age_q[i] - IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRY; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRY; i++) age_q[i] <= age_d[i];
    end
  end
`else
  // Lowest-index ready entry wins.
  always_comb begin
    disp_idx = '0;
    for (int i = NUM_ENTRY-1; i >= 0; i--) begin
      if (ready[i]) disp_idx = IDX_W'(i);
    end
  end
`endif

  assign disp_valid = |ready;
  assign disp_op    = disp_valid ? op_q[disp_idx] : '0;
  assign disp_a     = disp_valid ? vj_q[disp_idx] : '0;
  assign disp_b     = disp_valid ? vk_q[disp_idx] : '0;
  assign disp_tag   = disp_valid ? (TAG_W'(TAG_BASE) + TAG_W'(disp_idx)) : '0;

  // Flush discards every transfer of its cycle, so it masks both fires.
  assign issue_fire = issue_valid && issue_ready && !flush;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign cdb_hit    = cdb_valid && (cdb_tag != '0);
  assign bypass_j   = cdb_hit && (issue_qj == cdb_tag);
  assign bypass_k   = cdb_hit && (issue_qk == cdb_tag);

  // Entry next state: CDB capture for waiting operands, release on dispatch,
  // load on issue (with same-cycle CDB bypass), and flush overriding all.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      op_d[i] = op_q[i];
      vj_d[i] = vj_q[i];
      vk_d[i] = vk_q[i];
      qj_d[i] = qj_q[i];
      qk_d[i] = qk_q[i];

      if (busy_q[i] && cdb_hit && (qj_q[i] == cdb_tag)) begin
        vj_d[i] = cdb_data;
        qj_d[i] = '0;
      end
      if (busy_q[i] && cdb_hit && (qk_q[i] == cdb_tag)) begin
        vk_d[i] = cdb_data;
        qk_d[i] = '0;
      end

      if (disp_fire && (disp_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b0;
      end

      if (issue_fire && (free_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        vj_d[i]   = bypass_j ? cdb_data : issue_vj;
        qj_d[i]   = bypass_j ? '0 : issue_qj;
        vk_d[i]   = bypass_k ? cdb_data : issue_vk;
        qk_d[i]   = bypass_k ? '0 : issue_qk;
      end

      if (flush) begin
        busy_d[i] = 1'b0;
        qj_d[i]   = '0;
        qk_d[i]   = '0;
      end
    end
  end

  // Occupancy count tracks +issue -dispatch; both together cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (issue_fire && !disp_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue_fire && disp_fire) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign busy_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        op_q[i] <= op_d[i];
        vj_q[i] <= vj_d[i];
        vk_q[i] <= vk_d[i];
        qj_q[i] <= qj_d[i];
        qk_q[i] <= qk_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rsv_station.sv
// ---------------------------------------------------------------------------
// tb_rsv_station
//
// Directed bench for rsv_station with default parameters (4 entries, tags
// 1..4). Inputs change one time unit after each rising edge and outputs are
// sampled a further unit later, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_rsv_station;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [31:0] issue_vj;
  logic [31:0] issue_vk;
  logic [3:0]  issue_qj;
  logic [3:0]  issue_qk;
  logic [3:0]  issue_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_op;
  logic [31:0] disp_a;
  logic [31:0] disp_b;
  logic [3:0]  disp_tag;
  logic [2:0]  busy_cnt;

  int checks;
  int errors;

  rsv_station dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .issue_qj    (issue_qj),
    .issue_qk    (issue_qk),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_op     (disp_op),
    .disp_a      (disp_a),
    .disp_b      (disp_b),
    .disp_tag    (disp_tag),
    .busy_cnt    (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_vj    = '0;
    issue_vk    = '0;
    issue_qj    = '0;
    issue_qk    = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_data    = '0;
    disp_ready  = 1'b0;
  endtask

  task automatic setIssue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] qj, input logic [3:0] qk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    #3;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue_ready got %0b want 1", issue_ready); end
    checks++; if (issue_tag !== 4'd1) begin errors++; $display("[TB] FAIL reset_issue_tag got %0d want 1", issue_tag); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_disp_valid got %0b want 0", disp_valid); end
    checks++; if ({disp_op, disp_a, disp_b, disp_tag} !== '0) begin errors++; $display("[TB] FAIL reset_disp_fields got op=%0h a=%0h b=%0h tag=%0h want 0", disp_op, disp_a, disp_b, disp_tag); end
    checks++; if (busy_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_busy_cnt got %0d want 0", busy_cnt); end
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_issue();
    setIssue(4'd3, 32'd10, 32'd20, 4'd0, 4'd0);
    disp_ready = 1'b1;
    #1;
    checks++; if (issue_tag !== 4'd1) begin errors++; $display("[TB] FAIL basic_issue_tag got %0d want 1", issue_tag); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_same_cycle_disp got %0b want 0", disp_valid); end
    step();
    issue_valid = 1'b0;
    #1;
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_disp_valid got %0b want 1", disp_valid); end
    checks++; if ({disp_op, disp_a, disp_b, disp_tag} !== {4'd3, 32'd10, 32'd20, 4'd1}) begin errors++; $display("[TB] FAIL basic_disp_fields got op=%0d a=%0d b=%0d tag=%0d want 3 10 20 1", disp_op, disp_a, disp_b, disp_tag); end
    checks++; if (busy_cnt !== 3'd1) begin errors++; $display("[TB] FAIL basic_busy_one got %0d want 1", busy_cnt); end
    step();
    disp_ready = 1'b0;
    #1;
    checks++; if (busy_cnt !== 3'd0) begin errors++; $display("[TB] FAIL basic_busy_zero got %0d want 0", busy_cnt); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained got %0b want 0", disp_valid); end
  endtask

  task automatic test_cdb_wakeup();
    setIssue(4'd4, 32'd0, 32'd7, 4'd5, 4'd0);
    disp_ready = 1'b1;
    step();
    issue_valid = 1'b0;
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_wait1 got %0b want 0", disp_valid); end
    step();
    cdb_valid = 1'b1;
    cdb_tag   = 4'd5;
    cdb_data  = 32'd99;
    #1;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_no_forward got %0b want 0", disp_valid); end
    step();
    cdb_valid = 1'b0;
    #1;
    checks++; if ({disp_valid, disp_a, disp_b, disp_tag} !== {1'b1, 32'd99, 32'd7, 4'd1}) begin errors++; $display("[TB] FAIL wake_dispatch got v=%0b a=%0d b=%0d tag=%0d want 1 99 7 1", disp_valid, disp_a, disp_b, disp_tag); end
    step();
    disp_ready = 1'b0;
    #1;
    checks++; if (busy_cnt !== 3'd0) begin errors++; $display("[TB] FAIL wake_busy_zero got %0d want 0", busy_cnt); end
  endtask

  task automatic test_bypass();
    setIssue(4'd5, 32'd0, 32'd0, 4'd6, 4'd6);
    cdb_valid  = 1'b1;
    cdb_tag    = 4'd6;
    cdb_data   = 32'h55;
    disp_ready = 1'b1;
    step();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    #1;
    checks++; if ({disp_valid, disp_op, disp_a, disp_b, disp_tag} !== {1'b1, 4'd5, 32'h55, 32'h55, 4'd1}) begin errors++; $display("[TB] FAIL bypass_dispatch got v=%0b op=%0d a=%0h b=%0h tag=%0d want 1 5 55 55 1", disp_valid, disp_op, disp_a, disp_b, disp_tag); end
    step();
    disp_ready = 1'b0;
    #1;
    checks++; if (busy_cnt !== 3'd0) begin errors++; $display("[TB] FAIL bypass_busy_zero got %0d want 0", busy_cnt); end
  endtask

  task automatic test_full_and_flush();
    disp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setIssue(4'd7, 32'd0, 32'(i), 4'd9, 4'd0);
      #1;
      checks++; if (issue_tag !== 4'(i + 1)) begin errors++; $display("[TB] FAIL fill_issue_tag got %0d want %0d", issue_tag, i + 1); end
      step();
    end
    #1;
    checks++; if ({issue_ready, busy_cnt} !== {1'b0, 3'd4}) begin errors++; $display("[TB] FAIL full_state got ready=%0b cnt=%0d want 0 4", issue_ready, busy_cnt); end
    step();
    checks++; if (busy_cnt !== 3'd4) begin errors++; $display("[TB] FAIL full_ignore got %0d want 4", busy_cnt); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_none_ready got %0b want 0", disp_valid); end
    cdb_valid = 1'b1;
    cdb_tag   = 4'd9;
    cdb_data  = 32'h77;
    step();
    cdb_valid = 1'b0;
    #1;
    checks++; if ({disp_valid, disp_a, disp_b, disp_tag} !== {1'b1, 32'h77, 32'd0, 4'd1}) begin errors++; $display("[TB] FAIL full_wake got v=%0b a=%0h b=%0d tag=%0d want 1 77 0 1", disp_valid, disp_a, disp_b, disp_tag); end
    disp_ready = 1'b1;
    step();
    checks++; if ({issue_ready, issue_tag, busy_cnt} !== {1'b1, 4'd1, 3'd3}) begin errors++; $display("[TB] FAIL freed_tag got ready=%0b tag=%0d cnt=%0d want 1 1 3", issue_ready, issue_tag, busy_cnt); end
    checks++; if ({disp_tag, disp_b} !== {4'd2, 32'd1}) begin errors++; $display("[TB] FAIL next_offer got tag=%0d b=%0d want 2 1", disp_tag, disp_b); end
    step();
    checks++; if ({busy_cnt, issue_tag, disp_tag, disp_b} !== {3'd3, 4'd2, 4'd3, 32'd2}) begin errors++; $display("[TB] FAIL issue_and_dispatch got cnt=%0d itag=%0d dtag=%0d b=%0d want 3 2 3 2", busy_cnt, issue_tag, disp_tag, disp_b); end
    setIssue(4'd1, 32'd1, 32'd1, 4'd0, 4'd0);
    disp_ready = 1'b0;
    flush      = 1'b1;
    step();
    flush       = 1'b0;
    issue_valid = 1'b0;
    #1;
    checks++; if ({busy_cnt, disp_valid, issue_tag, issue_ready} !== {3'd0, 1'b0, 4'd1, 1'b1}) begin errors++; $display("[TB] FAIL flush_clear got cnt=%0d v=%0b tag=%0d ready=%0b want 0 0 1 1", busy_cnt, disp_valid, issue_tag, issue_ready); end
  endtask

  task automatic test_hold_and_reset();
    disp_ready = 1'b0;
    setIssue(4'd1, 32'h11, 32'h1, 4'd0, 4'd0);
    step();
    setIssue(4'd2, 32'h22, 32'h2, 4'd0, 4'd0);
    step();
    issue_valid = 1'b0;
    #1;
    checks++; if ({disp_valid, disp_op, disp_a, disp_tag, busy_cnt} !== {1'b1, 4'd1, 32'h11, 4'd1, 3'd2}) begin errors++; $display("[TB] FAIL hold_offer got v=%0b op=%0d a=%0h tag=%0d cnt=%0d want 1 1 11 1 2", disp_valid, disp_op, disp_a, disp_tag, busy_cnt); end
    step();
    checks++; if ({disp_valid, disp_op, disp_a, disp_tag} !== {1'b1, 4'd1, 32'h11, 4'd1}) begin errors++; $display("[TB] FAIL hold_stable got v=%0b op=%0d a=%0h tag=%0d want 1 1 11 1", disp_valid, disp_op, disp_a, disp_tag); end
    rst_n = 1'b0;
    #1;
    checks++; if ({disp_valid, busy_cnt, issue_tag} !== {1'b0, 3'd0, 4'd1}) begin errors++; $display("[TB] FAIL midreset got v=%0b cnt=%0d tag=%0d want 0 0 1", disp_valid, busy_cnt, issue_tag); end
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_dispatch_order();
    disp_ready = 1'b0;
    setIssue(4'd1, 32'hA1, 32'h0, 4'd0, 4'd0);
    step();
    setIssue(4'd2, 32'hB2, 32'h0, 4'd0, 4'd0);
    step();
    issue_valid = 1'b0;
    disp_ready  = 1'b1;
    step();
    disp_ready = 1'b0;
    setIssue(4'd3, 32'hC3, 32'h0, 4'd0, 4'd0);
    #1;
    checks++; if ({issue_tag, disp_tag} !== {4'd1, 4'd2}) begin errors++; $display("[TB] FAIL order_realloc got itag=%0d dtag=%0d want 1 2", issue_tag, disp_tag); end
    step();
    issue_valid = 1'b0;
    #1;
`ifdef RSV_STATION_AGE_ORDER_EN
    checks++; if ({disp_tag, disp_a} !== {4'd2, 32'hB2}) begin errors++; $display("[TB] FAIL order_oldest_first got tag=%0d a=%0h want 2 b2", disp_tag, disp_a); end
    disp_ready = 1'b1;
    step();
    checks++; if ({disp_tag, disp_a} !== {4'd1, 32'hC3}) begin errors++; $display("[TB] FAIL order_second got tag=%0d a=%0h want 1 c3", disp_tag, disp_a); end
`else
    checks++; if ({disp_tag, disp_a} !== {4'd1, 32'hC3}) begin errors++; $display("[TB] FAIL order_lowest_first got tag=%0d a=%0h want 1 c3", disp_tag, disp_a); end
    disp_ready = 1'b1;
    step();
    checks++; if ({disp_tag, disp_a} !== {4'd2, 32'hB2}) begin errors++; $display("[TB] FAIL order_second got tag=%0d a=%0h want 2 b2", disp_tag, disp_a); end
`endif
    step();
    disp_ready = 1'b0;
    #1;
    checks++; if ({busy_cnt, disp_valid} !== {3'd0, 1'b0}) begin errors++; $display("[TB] FAIL order_drained got cnt=%0d v=%0b want 0 0", busy_cnt, disp_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_bypass();
    test_full_and_flush();
    test_hold_and_reset();
    test_dispatch_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsv_station.md
Name: rsv_station

Overview:
- Reservation-station bank for one functional-unit class in the Tomasulo core.
- Sits directly downstream of the rename table. Issue logic delivers an operation with operand values or producer tags (Qj/Qk, 0 = value valid); the block writes back its own tag so the rename table can record the new producer.
- Entries snoop the common data bus (CDB) for pending operands and dispatch ready operations to the functional unit through a valid/ready handshake.

Parameters:
- NUM_ENTRY, 4: number of station entries (2..8).
- TAG_W, 4: tag width. Tag 0 is reserved for "value valid".
- DATA_W, 32: operand width.
- OP_W, 4: opcode width.
- TAG_BASE, 1: tag of entry 0. Entry i has tag TAG_BASE+i. Requirement: TAG_BASE ≥ 1 and TAG_BASE+NUM_ENTRY-1 < 2^TAG_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict/exception).
- issue_valid  in  1  issue request.
- issue_ready  out  1  a free entry exists.
- issue_op  in  OP_W  operation.
- issue_vj, issue_vk  in  DATA_W  operand values (meaningful when matching Q = 0).
- issue_qj, issue_qk  in  TAG_W  producer tags from the rename table.
- issue_tag  out  TAG_W  tag of the entry the next issue will occupy (to the rename table).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  producing tag.
- cdb_data  in  DATA_W  result value.
- disp_valid  out  1  an operation is offered to the functional unit.
- disp_ready  in  1  functional unit accepts.
- disp_op  out  OP_W  dispatched operation.
- disp_a, disp_b  out  DATA_W  dispatched operands.
- disp_tag  out  TAG_W  entry tag; the functional unit broadcasts it on the CDB.
- busy_cnt  out  $clog2(NUM_ENTRY+1)  number of occupied entries.

Behaviour:
- Per-entry state: busy, op, vj, vk, qj, qk. An entry is "ready" when busy && qj==0 && qk==0.
- Reset (async, rst_n=0): all busy=0 and all q fields=0. Outputs: issue_ready=1, issue_tag=TAG_BASE, disp_valid=0, disp_op/disp_a/disp_b=0, disp_tag=0, busy_cnt=0. Reset mid-operation drops all pending entries immediately.
- flush=1: all entries clear at the next edge. Issue, CDB capture and dispatch in that cycle are discarded. disp_valid may still be 1 combinationally in the flush cycle, but the functional unit must ignore it.
- Issue allocation:
  - Lowest-index free entry; issue_tag = TAG_BASE + that index, combinational.
  - issue_ready = any entry not busy, computed from current state. An entry freed by dispatch this cycle is not reusable until the next cycle.
  - Accept on issue_valid && issue_ready; the entry loads at the edge.
- CDB capture:
  - On cdb_valid with cdb_tag≠0, every busy entry with qj==cdb_tag loads vj=cdb_data and sets qj=0; qk likewise.
  - cdb_tag==0 is ignored.
- Issue/CDB same cycle: if issue_qj==cdb_tag (nonzero, cdb_valid), the new entry stores vj=cdb_data and qj=0 (bypass); same for k. Both operands may bypass from one broadcast.
- Dispatch:
  - Combinational select of the lowest-index ready entry.
  - disp_valid=1 when any entry is ready; disp_* reflect that entry. When no entry is ready, disp_op/disp_a/disp_b/disp_tag are 0.
  - On disp_valid && disp_ready the entry clears busy at the edge.
  - Latency: issue with both operands valid → earliest dispatch the next cycle. CDB wakeup → earliest dispatch the next cycle (no CDB-to-dispatch forwarding).
  - While disp_ready=0, the offered entry and disp_* hold stable unless an older-rule entry becomes ready (lowest-index rule is re-evaluated each cycle).
- busy_cnt: registered population count, updated by +issue −dispatch each edge. Simultaneous issue and dispatch leave it unchanged. Never exceeds NUM_ENTRY.
- Full: issue_ready=0 and issue_valid is ignored (no state change).
- Empty: disp_valid=0.

Optional Feature:
- Macro RSV_STATION_AGE_ORDER_EN.
- Defined: each entry has an age counter (width $clog2(NUM_ENTRY)) assigned from an issue sequence. Dispatch selects the oldest ready entry instead of the lowest index; on equal readiness, age wins.
- Undefined: lowest-index priority as above, with no age logic synthesized.
- Allocation policy is identical in both builds.

Test Plan:
- Reset, then issue op=3, vj=10, vk=20, qj=qk=0 → issue_tag=1 during issue; next cycle disp_valid=1, disp_a=10, disp_b=20, disp_tag=1; with disp_ready=1 busy_cnt returns to 0.
- Issue qj=5, qk=0, vk=7; broadcast cdb_tag=5, cdb_data=99 two cycles later → disp_valid stays 0 until the cycle after the broadcast, then disp_a=99, disp_b=7.
- Issue qj=qk=6 in the same cycle as cdb_valid, cdb_tag=6, cdb_data=0x55 → entry dispatches next cycle with disp_a=disp_b=0x55.
- Fill 4 entries with qj=9 → issue_ready=0 and a fifth issue is ignored (busy_cnt=4); dispatch with issue_valid held → the freed entry's tag appears on issue_tag the following cycle.
- Hold disp_ready=0 with 2 ready entries → disp_* stable, disp_tag=1; assert rst_n=0 mid-stream → disp_valid=0 and busy_cnt=0 immediately.
- With RSV_STATION_AGE_ORDER_EN: issue entries that occupy index 1 then index 0 (both ready) → index 1 (older) dispatches first, disp_tag=2.
